// File: rtl/sys_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sys_pkg : shared states, mode codes and width helpers              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sys_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_WAIT     = 3'd2,
        S_NEXT     = 3'd3,
        S_PASS_END = 3'd4,
        S_REDO     = 3'd5
    } state_t;

    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_BOTH  = 2'b11;

    function automatic int phase_w(input int l, input int n);
        return $clog2(l / n + 1);
    endfunction

    function automatic int block_w(input int l, input int k, input int n);
        return $clog2(l * k / n + 1);
    endfunction

    function automatic int rows_w(input int l);
        return $clog2(l + 1);
    endfunction

    function automatic int attempt_w(input int max_retry);
        return $clog2(max_retry + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/systemizer_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | systemizer_seq_if : phase-engine and matrix-regen handshake bundle |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface systemizer_seq_if
    import sys_pkg::*;
#(
    parameter int N = 20,
    parameter int L = 200,
    parameter int K = 400
);
    logic                          phase_start;
    logic                          phase_pivot;
    logic [phase_w(L, N)-1:0]      phase_idx;
    logic [block_w(L, K, N)-1:0]   phase_start_block;
    logic [block_w(L, K, N)-1:0]   phase_end_block;
    logic [rows_w(L)-1:0]          phase_rows;
    logic                          phase_done;
    logic                          phase_fail;
    logic                          regen_req;
    logic                          regen_ack;

    modport master (
        output phase_start, phase_pivot, phase_idx, phase_start_block,
               phase_end_block, phase_rows, regen_req,
        input  phase_done, phase_fail, regen_ack
    );

    modport slave (
        input  phase_start, phase_pivot, phase_idx, phase_start_block,
               phase_end_block, phase_rows, regen_req,
        output phase_done, phase_fail, regen_ack
    );
endinterface
`default_nettype wire

// File: rtl/sys_phase_cursor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sys_phase_cursor : phase index, start block and active row count   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sys_phase_cursor
    import sys_pkg::*;
#(
    parameter int N = 20,
    parameter int L = 200,
    parameter int K = 400
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        clear,
    input  wire logic                        advance,
    output logic [phase_w(L, N)-1:0]         idx,
    output logic [block_w(L, K, N)-1:0]      start_block,
    output logic [rows_w(L)-1:0]             rows,
    output logic                             last_phase
);
    localparam int PW = phase_w(L, N);
    localparam int BW = block_w(L, K, N);
    localparam int RW = rows_w(L);

    logic [PW-1:0] r_idx;
    logic [BW-1:0] r_start_block;
    logic [RW-1:0] r_rows;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= '0;
            r_start_block <= '0;
            r_rows        <= '0;
        end else if (clear) begin
            r_idx         <= '0;
            r_start_block <= '0;
            r_rows        <= RW'(L);
        end else if (advance) begin
            r_idx         <= r_idx + PW'(1);
            r_start_block <= r_start_block + BW'(L);
            // Remaining rows never drop below one block.
            r_rows        <= (r_rows > RW'(2 * N)) ? r_rows - RW'(N) : RW'(N);
        end
    end

    assign idx         = r_idx;
    assign start_block = r_start_block;
    assign rows        = r_rows;
    assign last_phase  = (r_idx == PW'(L / N - 1));

endmodule
`default_nettype wire

// File: rtl/systemizer_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | systemizer_seq : retry-capable sequencer for block Gaussian        |
// | systemization. Optional SYSTEMIZER_PERF_EN adds cycle/redo counts. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module systemizer_seq
    import sys_pkg::*;
#(
    parameter int N         = 20,
    parameter int L         = 200,
    parameter int K         = 400,
    parameter int MAX_RETRY = 3
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          start,
    input  wire logic [1:0]                    mode,
    input  wire logic                          abort,
    output logic                               busy,
    output logic [attempt_w(MAX_RETRY)-1:0]    attempt,
    output logic                               success,
    output logic                               fail,
`ifdef SYSTEMIZER_PERF_EN
    output logic [31:0]                        cycles,
    output logic [15:0]                        redo_total,
`endif
    systemizer_seq_if.master                   eng
);
    localparam int BW = block_w(L, K, N);
    localparam int AW = attempt_w(MAX_RETRY);
    localparam logic [BW-1:0] c_left_end  = BW'(L * L / N);
    localparam logic [BW-1:0] c_right_end = BW'(L * K / N);
    localparam logic [AW-1:0] c_max_retry = AW'(MAX_RETRY);

    state_t         r_state, w_next;
    logic [1:0]     r_mode;
    logic           r_left;
    logic [BW-1:0]  r_end_block;
    logic [AW-1:0]  r_attempt;
    logic           r_success, r_fail;

    logic w_clear, w_advance, w_accept, w_set_right, w_retry;
    logic w_success, w_fail, w_last, w_mode_valid, w_mode_left;

    assign w_mode_valid = (mode == MODE_LEFT) || (mode == MODE_RIGHT) || (mode == MODE_BOTH);
    assign w_mode_left  = (mode == MODE_LEFT) || (mode == MODE_BOTH);

    sys_phase_cursor #(.N(N), .L(L), .K(K)) u_cursor (
        .clk         (clk),
        .rst         (rst),
        .clear       (w_clear),
        .advance     (w_advance),
        .idx         (eng.phase_idx),
        .start_block (eng.phase_start_block),
        .rows        (eng.phase_rows),
        .last_phase  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_clear     = 1'b0;
        w_advance   = 1'b0;
        w_accept    = 1'b0;
        w_set_right = 1'b0;
        w_retry     = 1'b0;
        w_success   = 1'b0;
        w_fail      = 1'b0;
        if (abort && r_state != S_IDLE) begin
            w_next = S_IDLE;
            w_fail = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: if (start && w_mode_valid) begin
                    w_accept = 1'b1;
                    w_clear  = 1'b1;
                    w_next   = S_LAUNCH;
                end
                S_LAUNCH: w_next = S_WAIT;
                // A pivot failure outranks a simultaneous done; the right pass never pivots.
                S_WAIT: begin
                    if (eng.phase_fail && r_left) w_next = S_REDO;
                    else if (eng.phase_done)      w_next = w_last ? S_PASS_END : S_NEXT;
                end
                S_NEXT: begin
                    w_advance = 1'b1;
                    w_next    = S_LAUNCH;
                end
                S_PASS_END: begin
                    if (r_left && r_mode == MODE_BOTH) begin
                        w_clear     = 1'b1;
                        w_set_right = 1'b1;
                        w_next      = S_LAUNCH;
                    end else begin
                        w_success = 1'b1;
                        w_next    = S_IDLE;
                    end
                end
                S_REDO: begin
                    if (r_attempt > c_max_retry) begin
                        w_fail = 1'b1;
                        w_next = S_IDLE;
                    end else if (eng.regen_ack) begin
                        w_retry = 1'b1;
                        w_clear = 1'b1;
                        w_next  = S_LAUNCH;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= 2'b00;
            r_left      <= 1'b0;
            r_end_block <= '0;
            r_attempt   <= '0;
            r_success   <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_success <= w_success;
            r_fail    <= w_fail;
            if (w_accept) begin
                r_mode      <= mode;
                r_left      <= w_mode_left;
                r_end_block <= w_mode_left ? c_left_end : c_right_end;
                r_attempt   <= AW'(1);
            end else if (w_set_right) begin
                r_left      <= 1'b0;
                r_end_block <= c_right_end;
            end else if (w_retry) begin
                r_attempt   <= r_attempt + AW'(1);
                r_left      <= 1'b1;
                r_end_block <= c_left_end;
            end
        end
    end

`ifdef SYSTEMIZER_PERF_EN
    logic [31:0] r_cycles;
    logic [15:0] r_redo_total;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycles     <= '0;
            r_redo_total <= '0;
        end else begin
            if (w_accept)                                r_cycles <= '0;
            else if (r_state != S_IDLE && r_cycles != '1) r_cycles <= r_cycles + 32'd1;
            if (w_next == S_REDO && r_state == S_WAIT && r_redo_total != '1)
                r_redo_total <= r_redo_total + 16'd1;
        end
    end

    assign cycles     = r_cycles;
    assign redo_total = r_redo_total;
`endif

    assign busy                = (r_state != S_IDLE);
    assign attempt             = r_attempt;
    assign success             = r_success;
    assign fail                = r_fail;
    assign eng.phase_start     = (r_state == S_LAUNCH);
    assign eng.phase_pivot     = r_left;
    assign eng.phase_end_block = r_end_block;
    assign eng.regen_req       = (r_state == S_REDO) && (r_attempt <= c_max_retry);

endmodule
`default_nettype wire
